// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one single-port memory between NREQ
// requesters. Memory commands are registered (one cycle after the grant).
// Read data is routed back through a tag FIFO that records which requester
// owns each outstanding read. Memory returns read data in issue order.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   rq_req/rq_write   per-requester request and direction (1 = write)
//   rq_addr/rq_wdata  packed per-requester address and write data
//   rq_gnt            one-hot grant; the command is accepted this cycle
//   rq_rdata_vld      one-hot read-return strobe
//   rq_rdata          read data, broadcast to all requesters
//   mem_req/mem_write/mem_addr/mem_wdata   registered memory command
//   mem_rdata_vld/mem_rdata                read return from memory
//   err               sticky flag: read return seen with no read outstanding
//
// Optional feature, enabled by defining the macro MEM_ARB_PERF_EN:
//   perf_gnt_cnt   per-requester grant counters (NREQ x 32 bits, packed)
//   perf_conf_cnt  count of cycles with two or more eligible requesters
//   Both counters saturate at all-ones and are cleared by rst.
//
// Handshake: a requester holds rq_req and its command fields steady until it
// sees rq_gnt in the same cycle. The request is consumed at that clock edge.
// A requester may withdraw rq_req before it is granted. The memory side has
// no ready signal, because the memory accepts every command.
module mem_arb #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int NREQ   = 2,
  parameter int OUTST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        rq_req,
  input  logic [NREQ-1:0]        rq_write,
  input  logic [NREQ*MEM_AW-1:0] rq_addr,
  input  logic [NREQ*MEM_DW-1:0] rq_wdata,
  output logic [NREQ-1:0]        rq_gnt,
  output logic [NREQ-1:0]        rq_rdata_vld,
  output logic [MEM_DW-1:0]      rq_rdata,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [MEM_DW-1:0]      mem_wdata,
  input  logic                   mem_rdata_vld,
  input  logic [MEM_DW-1:0]      mem_rdata,
  output logic                   err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]     perf_gnt_cnt,
  output logic [31:0]            perf_conf_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(OUTST);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTST);

  logic [MEM_AW-1:0] addr_a  [NREQ];
  logic [MEM_DW-1:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = rq_addr[i*MEM_AW +: MEM_AW];
    assign wdata_a[i] = rq_wdata[i*MEM_DW +: MEM_DW];
  end

  logic [IW-1:0]   last_ptr;
  logic [IW-1:0]   win;
  logic            found;
  logic            gnt_any;
  logic [NREQ-1:0] elig;
  logic            push;
  logic            pop;
  logic            fifo_full;

  logic [IW-1:0]   tag_mem [OUTST];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // Fullness uses the pre-pop count. A pop in the same cycle does not make
  // room for a read grant until the next cycle. This keeps the grant path
  // independent of mem_rdata_vld.
  assign fifo_full = (count == FULL_CNT);

  always_comb begin
    elig  = rq_req & (rq_write | {NREQ{~fifo_full}});
    found = 1'b0;
    win   = '0;
    // Scan starts one past the last winner and wraps modulo NREQ.
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && elig[(int'(last_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(last_ptr) + k) % NREQ);
      end
    end
  end

  assign gnt_any = found & ~rst;
  assign rq_gnt  = gnt_any ? (NREQ'(1) << win) : '0;

  assign push = gnt_any & ~rq_write[win];
  assign pop  = mem_rdata_vld & (count != '0) & ~rst;

  // The return path is purely combinational: the head tag selects the
  // destination in the same cycle that the data arrives.
  assign rq_rdata_vld = pop ? (NREQ'(1) << tag_mem[rd_ptr]) : '0;
  assign rq_rdata     = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ptr  <= IW'(NREQ - 1);
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      mem_req <= gnt_any;
      if (gnt_any) begin
        mem_write <= rq_write[win];
        mem_addr  <= addr_a[win];
        mem_wdata <= wdata_a[win];
        last_ptr  <= win;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (mem_rdata_vld && (count == '0)) err <= 1'b1;
    end
  end

  // Tag storage needs no reset. The pointers and count define which entries
  // are valid.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= win;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] gnt_cnt [NREQ];
  logic        conflict;

  // Two or more bits are set exactly when clearing the lowest set bit
  // leaves a non-zero value.
  assign conflict = |(elig & (elig - NREQ'(1)));

  for (genvar i = 0; i < NREQ; i++) begin : g_perf
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gnt_cnt[i] <= '0;
      end else if (rq_gnt[i] && (gnt_cnt[i] != '1)) begin
        gnt_cnt[i] <= gnt_cnt[i] + 32'd1;
      end
    end
    assign perf_gnt_cnt[i*32 +: 32] = gnt_cnt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conf_cnt <= '0;
    end else if (conflict && (perf_conf_cnt != '1)) begin
      perf_conf_cnt <= perf_conf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with its default parameters
// (NREQ=2, OUTST=4, 16-bit address, 32-bit data). Inputs change 1 time unit
// after a rising edge. Combinational outputs are sampled 1 unit after that.
// Registered outputs are sampled 1 unit after the next rising edge.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  rq_req;
  logic [1:0]  rq_write;
  logic [31:0] rq_addr;
  logic [63:0] rq_wdata;
  logic [1:0]  rq_gnt;
  logic [1:0]  rq_rdata_vld;
  logic [31:0] rq_rdata;
  logic        mem_req;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdata_vld;
  logic [31:0] mem_rdata;
  logic        err;

  int tests_run;
  int tests_failed;

  mem_arb dut (
    .clk(clk),
    .rst(rst),
    .rq_req(rq_req),
    .rq_write(rq_write),
    .rq_addr(rq_addr),
    .rq_wdata(rq_wdata),
    .rq_gnt(rq_gnt),
    .rq_rdata_vld(rq_rdata_vld),
    .rq_rdata(rq_rdata),
    .mem_req(mem_req),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata_vld(mem_rdata_vld),
    .mem_rdata(mem_rdata),
    .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_rq(input logic [1:0] req, input logic [1:0] wr,
                          input logic [15:0] a0, input logic [15:0] a1);
    rq_req   = req;
    rq_write = wr;
    rq_addr  = {a1, a0};
  endtask

  task automatic drive_ret(input logic vld, input logic [31:0] data);
    mem_rdata_vld = vld;
    mem_rdata     = data;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    rq_req        = 2'b00;
    rq_write      = 2'b00;
    rq_addr       = '0;
    rq_wdata      = {32'h1111_2222, 32'hDEAD_BEEF};
    mem_rdata_vld = 1'b0;
    mem_rdata     = '0;

    // Reset state: registered outputs are zero, and grants are blocked
    // while rst is high.
    tick();
    tick();
    rq_req = 2'b01;
    settle();
    check("rst_mem_req",  64'(mem_req), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_err",      64'(err), 64'h0);
    check("rst_gnt",      64'(rq_gnt), 64'h0);
    rq_req = 2'b00;
    rst    = 1'b0;
    tick();

    // Single read from requester 0, data returned three cycles later.
    drive_rq(2'b01, 2'b00, 16'h0100, 16'h0000);
    settle();
    check("single_gnt", 64'(rq_gnt), 64'h1);
    tick();
    drive_rq(2'b00, 2'b00, 16'h0100, 16'h0000);
    check("single_mem_req",   64'(mem_req), 64'h1);
    check("single_mem_addr",  64'(mem_addr), 64'h100);
    check("single_mem_write", 64'(mem_write), 64'h0);
    tick();
    check("single_idle_req", 64'(mem_req), 64'h0);
    check("single_hold_addr", 64'(mem_addr), 64'h100);
    tick();
    drive_ret(1'b1, 32'h100);
    settle();
    check("single_vld",   64'(rq_rdata_vld), 64'h1);
    check("single_rdata", 64'(rq_rdata), 64'h100);
    check("single_err",   64'(err), 64'h0);
    tick();
    drive_ret(1'b0, 32'h0);

    // Both requesters read continuously. Requester 0 won last, so the
    // grants go 1,0,1,0 and the FIFO becomes full.
    drive_rq(2'b11, 2'b00, 16'h0010, 16'h0020);
    settle();
    check("rr_gnt_a", 64'(rq_gnt), 64'h2);
    tick();
    check("rr_addr_a", 64'(mem_addr), 64'h20);
    check("rr_gnt_b", 64'(rq_gnt), 64'h1);
    tick();
    check("rr_addr_b", 64'(mem_addr), 64'h10);
    check("rr_gnt_c", 64'(rq_gnt), 64'h2);
    tick();
    check("rr_addr_c", 64'(mem_addr), 64'h20);
    check("rr_gnt_d", 64'(rq_gnt), 64'h1);
    tick();
    check("rr_addr_d", 64'(mem_addr), 64'h10);
    // FIFO is full, so neither read is eligible.
    check("full_no_gnt", 64'(rq_gnt), 64'h0);
    tick();
    check("full_idle_req", 64'(mem_req), 64'h0);

    // A write from requester 0 is still granted while the FIFO is full.
    drive_rq(2'b11, 2'b01, 16'h0010, 16'h0020);
    settle();
    check("full_wr_gnt", 64'(rq_gnt), 64'h1);
    tick();
    check("full_wr_mem_write", 64'(mem_write), 64'h1);
    check("full_wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    drive_rq(2'b10, 2'b00, 16'h0010, 16'h0020);
    settle();
    check("full_rd_wait", 64'(rq_gnt), 64'h0);
    tick();
    // A pop does not free a slot in the same cycle. The head tag is 1.
    drive_ret(1'b1, 32'h11);
    settle();
    check("full_pop_no_gnt", 64'(rq_gnt), 64'h0);
    check("full_pop_vld",    64'(rq_rdata_vld), 64'h2);
    check("full_pop_rdata",  64'(rq_rdata), 64'h11);
    tick();
    drive_ret(1'b0, 32'h0);
    settle();
    check("after_pop_gnt", 64'(rq_gnt), 64'h2);
    tick();
    drive_rq(2'b00, 2'b00, 16'h0010, 16'h0020);
    check("after_pop_mem_req",  64'(mem_req), 64'h1);
    check("after_pop_mem_addr", 64'(mem_addr), 64'h20);

    // Drain the FIFO. It now holds tags 0,1,0,1.
    drive_ret(1'b1, 32'h21);
    settle();
    check("drain_vld_0", 64'(rq_rdata_vld), 64'h1);
    tick();
    drive_ret(1'b1, 32'h22);
    settle();
    check("drain_vld_1", 64'(rq_rdata_vld), 64'h2);
    check("drain_rdata_1", 64'(rq_rdata), 64'h22);
    tick();
    drive_ret(1'b1, 32'h23);
    settle();
    check("drain_vld_2", 64'(rq_rdata_vld), 64'h1);
    tick();
    drive_ret(1'b1, 32'h24);
    settle();
    check("drain_vld_3", 64'(rq_rdata_vld), 64'h2);
    tick();
    drive_ret(1'b0, 32'h0);

    // Interleaved reads 0:'h200, 1:'h300, 0:'h204. The third grant happens
    // in the same cycle as the first return (push and pop together).
    drive_rq(2'b01, 2'b00, 16'h0200, 16'h0300);
    settle();
    check("il_gnt_0", 64'(rq_gnt), 64'h1);
    tick();
    check("il_addr_0", 64'(mem_addr), 64'h200);
    drive_rq(2'b10, 2'b00, 16'h0200, 16'h0300);
    settle();
    check("il_gnt_1", 64'(rq_gnt), 64'h2);
    tick();
    check("il_addr_1", 64'(mem_addr), 64'h300);
    drive_rq(2'b01, 2'b00, 16'h0204, 16'h0300);
    drive_ret(1'b1, 32'hA0);
    settle();
    check("il_gnt_2", 64'(rq_gnt), 64'h1);
    check("il_vld_0", 64'(rq_rdata_vld), 64'h1);
    tick();
    drive_rq(2'b00, 2'b00, 16'h0204, 16'h0300);
    check("il_addr_2", 64'(mem_addr), 64'h204);
    drive_ret(1'b1, 32'hA1);
    settle();
    check("il_vld_1", 64'(rq_rdata_vld), 64'h2);
    check("il_rdata_1", 64'(rq_rdata), 64'hA1);
    tick();
    drive_ret(1'b1, 32'hA2);
    settle();
    check("il_vld_2", 64'(rq_rdata_vld), 64'h1);
    tick();

    // Stray return with nothing outstanding: data is dropped and err sticks.
    drive_ret(1'b1, 32'hBAD);
    settle();
    check("stray_vld", 64'(rq_rdata_vld), 64'h0);
    check("stray_err_before", 64'(err), 64'h0);
    tick();
    drive_ret(1'b0, 32'h0);
    check("stray_err_set", 64'(err), 64'h1);
    tick();
    tick();
    check("stray_err_held", 64'(err), 64'h1);

    // Reset with two reads outstanding. The last grant went to 0, so the
    // next winner is 1, then 0.
    drive_rq(2'b11, 2'b00, 16'h0400, 16'h0500);
    settle();
    check("mid_gnt_a", 64'(rq_gnt), 64'h2);
    tick();
    settle();
    check("mid_gnt_b", 64'(rq_gnt), 64'h1);
    tick();
    rst = 1'b1;
    settle();
    check("mid_rst_mem_req", 64'(mem_req), 64'h0);
    check("mid_rst_err",     64'(err), 64'h0);
    check("mid_rst_gnt",     64'(rq_gnt), 64'h0);
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_gnt", 64'(rq_gnt), 64'h1);
    tick();
    drive_rq(2'b00, 2'b00, 16'h0400, 16'h0500);
    check("post_rst_mem_addr", 64'(mem_addr), 64'h400);
    // Only the post-reset read is outstanding, and requester 0 owns it.
    drive_ret(1'b1, 32'hC0);
    settle();
    check("post_rst_vld", 64'(rq_rdata_vld), 64'h1);
    tick();
    drive_ret(1'b0, 32'h0);
    check("post_rst_err", 64'(err), 64'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
